sbox_ram_ctrl: RTL
==================

// Module: sbox_ram_ctrl
// PURPOSE
//  Parametrised RC4 S-box state memory with built-in sequential initialisation and an atomic swap engine.
//  Replaces the 256-entry reset loop with a DEPTH-cycle init FSM that writes S[k]=k.
//  Serves the KSA and PRGA stages through two registered read ports, one direct write port
//  and an atomic swap of S[i], S[j] behind a valid/ready handshake.
// PARAMETERS
//  ADDR_W   8   address width; DEPTH = 2**ADDR_W entries (localparam)
//  DATA_W   8   entry width; init value of entry k is k mod 2**DATA_W
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  init_req     in   1       synchronous request to re-run initialisation
//  init_done    out  1       1 = memory initialised and usable
//  rd_addr_0    in   ADDR_W  read port 0 address
//  rd_data_0    out  DATA_W  read port 0 data, 1-cycle latency
//  rd_addr_1    in   ADDR_W  read port 1 address
//  rd_data_1    out  DATA_W  read port 1 data, 1-cycle latency
//  wr_en        in   1       direct write strobe
//  wr_addr      in   ADDR_W  direct write address
//  wr_data      in   DATA_W  direct write data
//  ready        out  1       1 = IDLE; swap and direct write accepted this cycle
//  swap_valid   in   1       swap request
//  swap_i       in   ADDR_W  swap index i
//  swap_j       in   ADDR_W  swap index j
//  swap_done    out  1       1-cycle pulse when swap writes commit
// BEHAVIOUR
//  Reset (async): state=INIT, init_cnt=0, init_done=0, ready=0, swap_done=0, rd_data_0/1=0. Memory array is not reset.
//  States: INIT, IDLE, SWAP_RD, SWAP_WR.
//  INIT: each edge writes mem[init_cnt]=init_cnt[DATA_W-1:0] and increments init_cnt.
//   The write at init_cnt=DEPTH-1 moves to IDLE, sets init_done=1, ready=1.
//   init_done rises exactly DEPTH edges after rst deasserts. The wr_en and swap inputs are ignored.
//  IDLE: ready=1.
//   wr_en=1: mem[wr_addr]=wr_data at this edge.
//   swap_valid=1: latch swap_i/swap_j, go to SWAP_RD.
//   Both in the same cycle: both are accepted; the swap reads the newly written data.
//  SWAP_RD: capture t_i=mem[i], t_j=mem[j]; go to SWAP_WR. ready=0.
//  SWAP_WR: mem[i]=t_j and mem[j]=t_i at this edge; swap_done=1 during this cycle; go to IDLE.
//   If i==j, the entry is unchanged (single write of t_i).
//  Swap throughput is 1 per 3 cycles. A new swap can be accepted the cycle after swap_done.
//  Read ports: rd_data_n <= mem[rd_addr_n] every edge. While init_done=0, rd_data_n <= 0.
//   A read of an address written at the same edge returns the old value (read-before-write).
//  wr_en or swap_valid while ready=0: dropped, with no side effect. Requesters must hold until ready.
//  init_req=1 in any state: at the next edge go to INIT with init_cnt=0, init_done=0, ready=0.
//   Any in-flight swap is aborted with no partial write and no swap_done. init_req has priority over wr_en and swap.
//  init_req held high: init_cnt holds at 0 and writes mem[0]=0 each cycle.
//  Address arithmetic is modulo DEPTH. init_cnt is ADDR_W+1 bits wide to detect the end of INIT.
//  rst asserted mid-operation: immediate return to the reset values. Contents of the aborted swap are undefined.
// TESTING
//  1. Release rst, defaults -> init_done=0 for 255 edges, 1 after edge 256; read S[0]=0x00, S[255]=0xFF, S[0x5A]=0x5A.
//  2. After init, swap i=0x03 j=0xF0 -> swap_done on 3rd cycle after accept; S[0x03]=0xF0, S[0xF0]=0x03; ready low 2 cycles.
//  3. Swap i=j=0x10 -> S[0x10] stays 0x10; swap_done pulses once.
//  4. wr_en addr 0x07 data 0xAA with swap i=0x07 j=0x08 same cycle -> S[0x07]=0x08, S[0x08]=0xAA.
//  5. Read 0x03 at the SWAP_WR edge of swap (0x03, 0x04) -> rd_data returns 0x03 that cycle, 0x04 on the next read.
//  6. init_req during SWAP_RD -> no swap_done; init_done=0; after 256 cycles all S[k]=k; ADDR_W=4, DATA_W=8 run gives 16-cycle init.

Source files
------------

// File: rtl/sbox_ram_ctrl.sv
// RC4 S-box state memory: sequential S[k]=k initialisation, two registered read ports,
// a direct write port and an atomic S[i]/S[j] swap engine behind a ready handshake.
module sbox_ram_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_req_i,
  output logic              init_done_o,
  input  logic [ADDR_W-1:0] rd_addr_0_i,
  output logic [DATA_W-1:0] rd_data_0_o,
  input  logic [ADDR_W-1:0] rd_addr_1_i,
  output logic [DATA_W-1:0] rd_data_1_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              ready_o,
  input  logic              swap_valid_i,
  input  logic [ADDR_W-1:0] swap_i_i,
  input  logic [ADDR_W-1:0] swap_j_i,
  output logic              swap_done_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {StInit, StIdle, StSwapRd, StSwapWr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0]   swap_i_q, swap_i_d, swap_j_q, swap_j_d;
  logic [DATA_W-1:0]   t_i_q, t_i_d, t_j_q, t_j_d;
  logic [DATA_W-1:0]   rd_data_0_q, rd_data_1_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                we0, we1;
  logic [ADDR_W-1:0]   wa0, wa1;
  logic [DATA_W-1:0]   wd0, wd1;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    swap_i_d   = swap_i_q;
    swap_j_d   = swap_j_q;
    t_i_d      = t_i_q;
    t_j_d      = t_j_q;
    we0        = 1'b0;
    we1        = 1'b0;
    wa0        = '0;
    wa1        = '0;
    wd0        = '0;
    wd1        = '0;

    unique case (state_q)
      StInit: begin
        we0        = 1'b1;
        wa0        = init_cnt_q[ADDR_W-1:0];
        wd0        = DATA_W'(init_cnt_q[ADDR_W-1:0]);
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_d[ADDR_W]) state_d = StIdle;
      end
      StIdle: begin
        if (wr_en_i) begin
          we0 = 1'b1;
          wa0 = wr_addr_i;
          wd0 = wr_data_i;
        end
        if (swap_valid_i) begin
          swap_i_d = swap_i_i;
          swap_j_d = swap_j_i;
          state_d  = StSwapRd;
        end
      end
      StSwapRd: begin
        t_i_d   = mem_q[swap_i_q];
        t_j_d   = mem_q[swap_j_q];
        state_d = StSwapWr;
      end
      StSwapWr: begin
        we0     = 1'b1;
        wa0     = swap_i_q;
        wd0     = t_j_q;
        // i == j leaves the entry unchanged, so the second write is skipped.
        we1     = (swap_i_q != swap_j_q);
        wa1     = swap_j_q;
        wd1     = t_i_q;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase

    // Re-initialisation wins over everything and aborts any pending swap write.
    if (init_req_i) begin
      state_d    = StInit;
      init_cnt_d = '0;
      if (state_q != StInit) begin
        we0 = 1'b0;
        we1 = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      swap_i_q   <= '0;
      swap_j_q   <= '0;
      t_i_q      <= '0;
      t_j_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      swap_i_q   <= swap_i_d;
      swap_j_q   <= swap_j_d;
      t_i_q      <= t_i_d;
      t_j_q      <= t_j_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we0) mem_q[wa0] <= wd0;
    if (we1) mem_q[wa1] <= wd1;
  end

  // Read-before-write: the array value sampled here predates this edge's writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_0_q <= '0;
      rd_data_1_q <= '0;
    end else if (state_q == StInit) begin
      rd_data_0_q <= '0;
      rd_data_1_q <= '0;
    end else begin
      rd_data_0_q <= mem_q[rd_addr_0_i];
      rd_data_1_q <= mem_q[rd_addr_1_i];
    end
  end

  assign init_done_o = (state_q != StInit);
  assign ready_o     = (state_q == StIdle);
  assign swap_done_o = (state_q == StSwapWr) && !init_req_i;
  assign rd_data_0_o = rd_data_0_q;
  assign rd_data_1_o = rd_data_1_q;

endmodule
